// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: decides when the ADS7883 driver converts (periodic
// timer or single-shot request), runs a burst of 2^AVG_LOG2 conversions,
// averages them and hands the result out on a valid/ready port. Stalled
// conversions abort with a sticky timeout flag. Results that overwrite an
// unread result raise a sticky overrun flag.
module adc_sample_scheduler #(
  parameter int DIV_W    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] period,
  input  logic             start,
  input  logic             clr,
  output logic             adc_en,
  input  logic             adc_cs,
  input  logic [11:0]      adc_data,
  output logic [11:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int ACC_W  = 12 + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  NSAMP = CNT_W'(1 << AVG_LOG2);
  localparam logic [WCNT_W-1:0] WLIM  = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_LOW, S_WAIT_HIGH, S_CAPTURE, S_RESULT
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   tcnt_q, tcnt_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   scnt_q, scnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [11:0]        out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               tick;
  logic               overrun_set;
  logic               timeout_set;

  // Periodic timer: one tick every `period` cycles, silent when period is 0.
  always_comb begin
    tick   = (period != '0) && (tcnt_q == '0);
    tcnt_d = tcnt_q;
    if (period == '0) begin
      tcnt_d = '0;
    end else if (tcnt_q == '0) begin
      tcnt_d = period - DIV_W'(1);
    end else begin
      tcnt_d = tcnt_q - DIV_W'(1);
    end
  end

  // Burst sequencer, accumulator, wait watchdog and output/flag next state.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q | tick | start;
    scnt_d      = scnt_q;
    acc_d       = acc_q;
    wcnt_d      = wcnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;
    overrun_set = 1'b0;
    timeout_set = 1'b0;
    adc_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        scnt_d = '0;
        acc_d  = '0;
        if (pend_q || start || tick) begin
          state_d = S_TRIG;
          pend_d  = 1'b0;
        end
      end
      S_TRIG: begin
        adc_en  = 1'b1;
        wcnt_d  = '0;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!adc_cs) begin
          wcnt_d  = '0;
          state_d = S_WAIT_HIGH;
        end else if (wcnt_q == WLIM) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (adc_cs) begin
          state_d = S_CAPTURE;
        end else if (wcnt_q == WLIM) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_CAPTURE: begin
        acc_d   = acc_q + ACC_W'(adc_data);
        scnt_d  = scnt_q + CNT_W'(1);
        state_d = (scnt_d == NSAMP) ? S_RESULT : S_TRIG;
      end
      S_RESULT: begin
        out_data_d  = acc_q[ACC_W-1:AVG_LOG2];
        out_valid_d = 1'b1;
        overrun_set = out_valid_q & ~out_ready;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    overrun_d = overrun_set | (overrun_q & ~clr);
    timeout_d = timeout_set | (timeout_q & ~clr);
  end

  // State and datapath registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      pend_q      <= 1'b0;
      scnt_q      <= '0;
      acc_q       <= '0;
      wcnt_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      pend_q      <= pend_d;
      scnt_q      <= scnt_d;
      acc_q       <= acc_d;
      wcnt_q      <= wcnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: randomized driver model plus a
// transaction-level averaging reference and directed boundary scenarios.
module tb_adc_sample_scheduler;

  localparam int DIV_W    = 16;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 64;
  localparam int NS       = 1 << AVG_LOG2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] period;
  logic             start;
  logic             clr;
  logic             adc_en;
  logic             adc_cs;
  logic [11:0]      adc_data;
  logic [11:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             timeout_err;

  always #5 clk = ~clk;

  adc_sample_scheduler #(.DIV_W(DIV_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .period(period), .start(start), .clr(clr),
    .adc_en(adc_en), .adc_cs(adc_cs), .adc_data(adc_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference model: every NS delivered samples form one expected average.
  int m_sum = 0;
  int m_cnt = 0;
  int exp_q[$];
  int vals[$];

  function automatic void model_push(input int v);
    m_sum += v;
    m_cnt++;
    if (m_cnt == NS) begin
      exp_q.push_back(m_sum / NS);
      m_sum = 0;
      m_cnt = 0;
    end
  endfunction

  task automatic flush_model();
    m_sum = 0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // Driver model: answers each adc_en with a random-length cs-low transfer.
  logic hang = 1'b0;
  initial begin
    int d1, len, v;
    adc_cs   = 1'b1;
    adc_data = '0;
    forever begin
      @(negedge clk);
      if (adc_en && !hang) begin
        d1  = $urandom_range(1, 3);
        len = $urandom_range(2, 25);
        repeat (d1) @(negedge clk);
        adc_cs = 1'b0;
        repeat (len) @(negedge clk);
        v = (vals.size() > 0) ? vals.pop_front() : int'($urandom_range(0, 4095));
        adc_data = 12'(v);
        adc_cs   = 1'b1;
        model_push(v);
      end
    end
  end

  // Monitor: protocol rules, burst starts, and scoreboard on accepted results.
  int unsigned cyc = 0;
  int unsigned starts[$];
  int  en_cnt   = 0;
  int  viol     = 0;
  int  spurious = 0;
  bit  sb_en    = 1'b0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    logic en_prev, busy_prev;
    en_prev   = 1'b0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (adc_en) en_cnt++;
      if (adc_en && (en_prev || !adc_cs)) viol++;
      if (adc_en && !busy_prev) starts.push_back(cyc);
      en_prev   = adc_en;
      busy_prev = busy;
      if (sb_en && out_valid && out_ready) begin
        if (exp_q.size() == 0) spurious++;
        else check_eq("sb_result", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick_n(1);
    clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int quiet, n;
    quiet = 0;
    n     = 0;
    while (quiet < 3 && n < maxc) begin
      tick_n(1);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    check_eq({tag, "_idle"}, 32'(quiet >= 3), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int n;
    n = 0;
    while (!out_valid && n < maxc) begin
      tick_n(1);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int n, a, exp_avg;
    rst_n     = 1'b0;
    period    = '0;
    start     = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    tick_n(3);
    check_eq("rst_adc_en", 32'(adc_en), 0);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_overrun", 32'(overrun), 0);
    check_eq("rst_timeout", 32'(timeout_err), 0);
    rst_n = 1'b1;
    tick_n(3);

    // Single shot with known samples.
    vals   = '{100, 101, 102, 103};
    en_cnt = 0;
    pulse_start();
    check_eq("lat_busy", 32'(busy), 1);
    check_eq("lat_adc_en", 32'(adc_en), 1);
    tick_n(1);
    check_eq("en_one_cycle", 32'(adc_en), 0);
    wait_valid("single", 800);
    check_eq("single_data", 32'(out_data), 101);
    check_eq("single_pulses", 32'(en_cnt), 4);
    tick_n(20);
    check_eq("single_hold", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick_n(1);
    check_eq("single_drop", 32'(out_valid), 0);
    flush_model();

    // Randomized bursts against the scoreboard, with merged repeat requests.
    sb_en    = 1'b1;
    spurious = 0;
    for (int it = 0; it < 10; it++) begin
      pulse_start();
      if ($urandom_range(0, 1) == 1) begin
        tick_n($urandom_range(3, 60));
        pulse_start();
      end
      wait_idle("rand", 1500);
    end
    check_eq("rand_drain", 32'(exp_q.size()), 0);

    // Periodic triggering, then disabled.
    starts.delete();
    period = DIV_W'(200);
    n = 0;
    while (starts.size() < 4 && n < 1500) begin
      tick_n(1);
      n++;
    end
    period = '0;
    check_eq("per_bursts", 32'(starts.size() >= 4), 1);
    if (starts.size() >= 4)
      for (int i = 1; i < 4; i++) check_eq("per_gap", starts[i] - starts[i-1], 200);
    wait_idle("per", 1000);
    starts.delete();
    tick_n(600);
    check_eq("per_off", 32'(starts.size()), 0);
    check_eq("per_drain", 32'(exp_q.size()), 0);

    // Tick and start together, plus repeated starts during the burst.
    starts.delete();
    period = DIV_W'(300);
    pulse_start();
    tick_n(4);
    period = '0;
    pulse_start();
    tick_n(5);
    pulse_start();
    wait_idle("merge", 2000);
    check_eq("merge_bursts", 32'(starts.size()), 2);
    check_eq("merge_drain", 32'(exp_q.size()), 0);

    // Back-pressure: second result overwrites the first.
    sb_en     = 1'b0;
    out_ready = 1'b0;
    flush_model();
    vals = '{12'h0AA, 12'h0AA, 12'h0AA, 12'h0AA, 12'h155, 12'h155, 12'h155, 12'h155};
    pulse_start();
    wait_valid("ovr1", 800);
    check_eq("ovr1_data", 32'(out_data), 32'h0AA);
    check_eq("ovr1_flag", 32'(overrun), 0);
    pulse_start();
    wait_idle("ovr2", 800);
    check_eq("ovr2_data", 32'(out_data), 32'h155);
    check_eq("ovr2_valid", 32'(out_valid), 1);
    check_eq("ovr2_flag", 32'(overrun), 1);
    pulse_clr();
    check_eq("ovr_clr", 32'(overrun), 0);
    check_eq("ovr_clr_valid", 32'(out_valid), 1);

    // Stalled driver: abort after TIMEOUT cycles in WAIT_LOW.
    hang = 1'b1;
    pulse_start();
    n = 0;
    while (busy && n < 300) begin
      tick_n(1);
      n++;
    end
    check_eq("to_cycles", 32'(n), 32'(TIMEOUT + 1));
    check_eq("to_flag", 32'(timeout_err), 1);
    check_eq("to_busy", 32'(busy), 0);
    check_eq("to_valid", 32'(out_valid), 1);
    check_eq("to_data", 32'(out_data), 32'h155);
    hang = 1'b0;
    pulse_clr();
    check_eq("to_clr", 32'(timeout_err), 0);

    // Asynchronous reset while waiting for cs to return high.
    pulse_start();
    n = 0;
    while (adc_cs && n < 50) begin
      tick_n(1);
      n++;
    end
    tick_n(1);
    check_eq("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid), 0);
    check_eq("arst_data", 32'(out_data), 0);
    check_eq("arst_busy", 32'(busy), 0);
    check_eq("arst_adc_en", 32'(adc_en), 0);
    tick_n(2);
    rst_n = 1'b1;
    n = 0;
    while (!adc_cs && n < 100) begin
      tick_n(1);
      n++;
    end
    tick_n(3);
    check_eq("post_rst_idle", 32'(busy), 0);
    flush_model();
    vals.delete();
    a = 0;
    for (int i = 0; i < NS; i++) begin
      int v;
      v = $urandom_range(0, 4095);
      vals.push_back(v);
      a += v;
    end
    exp_avg   = a / NS;
    out_ready = 1'b1;
    sb_en     = 1'b1;
    pulse_start();
    wait_valid("fresh", 800);
    check_eq("fresh_data", 32'(out_data), 32'(exp_avg));
    wait_idle("fresh", 400);

    check_eq("en_rules", 32'(viol), 0);
    check_eq("sb_spurious", 32'(spurious), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
